// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder
//   Accepts a 3-bit requester index and holds a registered one-hot grant
//   until the holder releases it. Two states: IDLE (ready for an index) and
//   GRANT (one bit of out asserted).
//
//   Optional feature macro: GRANT_TIMEOUT_EN
//     When defined, a hold counter revokes a grant that has been held for
//     HOLD_MAX cycles without a release. The revocation is flagged by a
//     one-cycle timeout pulse. When undefined, the counter does not exist,
//     timeout is tied low, and a grant persists until release or reset.
//
// Handshake: an index is accepted at a rising edge where in_valid and
//   in_ready are both 1. in_ready is 1 exactly when the block is in IDLE.
//   in_valid and in are ignored while a grant is held.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   in[2:0]       binary index of the requester to grant
//   in_valid      in is valid this cycle
//   in_ready      block accepts an index this cycle (IDLE)
//   grant_release current grant holder gives up the grant
//   out[7:0]      registered one-hot grant vector (8'h00 in IDLE)
//   busy          a grant is currently asserted
//   timeout       one-cycle pulse when a grant is revoked by timeout
//   grant_count   grants issued since reset, wrapping at 8 bits
//   dbg_state     current FSM state (0 = IDLE, 1 = GRANT)
module onehot_grant_decoder #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       grant_release,
  output logic [7:0] out,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] grant_count,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [7:0] out_d;
  logic       accept;
  logic       revoke;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == GRANT);
  assign dbg_state = (state_q == GRANT);
  assign accept    = in_valid && in_ready;

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;

  // A release on the same edge wins over the timeout.
  assign revoke  = (state_q == GRANT) && (hold_q == HOLD_MAX_C) && !grant_release;
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q <= 8'h00;
      end else if (state_q == GRANT) begin
        hold_q <= hold_q + 8'h01;
      end
      // The state is IDLE in the cycle after a revoke, so this is one cycle wide.
      timeout_q <= revoke;
    end
  end
`else
  logic unused_hold_max;

  assign unused_hold_max = ^HOLD_MAX_C;
  assign revoke          = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = GRANT;
          out_d   = 8'h01 << in;
        end
      end
      GRANT: begin
        if (grant_release || revoke) begin
          state_d = IDLE;
          out_d   = 8'h00;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out         <= 8'h00;
      grant_count <= 8'h00;
    end else begin
      state_q <= state_d;
      out     <= out_d;
      if (accept) begin
        grant_count <= grant_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_onehot_grant_decoder.sv
module tb_onehot_grant_decoder;

  logic       clk;
  logic       rst_n;
  logic [2:0] in;
  logic       in_valid;
  logic       in_ready;
  logic       grant_release;
  logic [7:0] out;
  logic       busy;
  logic       timeout;
  logic [7:0] grant_count;
  logic       dbg_state;

  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_cnt;
  logic [7:0] exp_out;

  onehot_grant_decoder #(.HOLD_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .grant_release(grant_release),
    .out          (out),
    .busy         (busy),
    .timeout      (timeout),
    .grant_count  (grant_count),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [2:0] idx);
    in       = idx;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 8'h01;
  endtask

  task automatic do_release();
    grant_release = 1'b1;
    step();
    grant_release = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; in = 3'd0; in_valid = 1'b0; grant_release = 1'b0;
    exp_cnt = 8'h00;
    #3;
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_cmp++; if (grant_count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", grant_count); end
    step();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_held_out: got %h want 00", out); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    // First edge after reset release accepts.
    do_accept(3'd5);
    n_cmp++; if (out !== 8'h20) begin n_bad++; $display("FAIL single_out: got %h want 20", out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (grant_count !== 8'h01) begin n_bad++; $display("FAIL single_count: got %h want 01", grant_count); end
    n_cmp++; if (dbg_state !== 1'b1) begin n_bad++; $display("FAIL single_state: got %b want 1", dbg_state); end
    do_release();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL single_rel_out: got %h want 00", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_rel_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_rel_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sweep();
    logic [7:0] tbl [8];
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) begin
      do_accept(3'(i));
      n_cmp++; if (out !== tbl[i]) begin n_bad++; $display("FAIL sweep_out[%0d]: got %h want %h", i, out, tbl[i]); end
      do_release();
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL sweep_gap[%0d]: got %h want 00", i, out); end
    end
    n_cmp++; if (grant_count !== 8'h09) begin n_bad++; $display("FAIL sweep_count: got %h want 09", grant_count); end
  endtask

  task automatic test_ignore_in_grant();
    do_accept(3'd2);
    n_cmp++; if (out !== 8'h04) begin n_bad++; $display("FAIL ign_first: got %h want 04", out); end
    in = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out !== 8'h04) begin n_bad++; $display("FAIL ign_hold[%0d]: got %h want 04", i, out); end
    end
    n_cmp++; if (grant_count !== exp_cnt) begin n_bad++; $display("FAIL ign_count: got %h want %h", grant_count, exp_cnt); end
    // Release while in_valid stays high: one empty cycle, then accept.
    grant_release = 1'b1;
    step();
    grant_release = 1'b0;
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL ign_gap: got %h want 00", out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ign_gap_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 8'h01;
    n_cmp++; if (out !== 8'h80) begin n_bad++; $display("FAIL ign_new: got %h want 80", out); end
    do_release();
  endtask

  task automatic test_release_idle();
    grant_release = 1'b1;
    step();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL relidle_out: got %h want 00", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL relidle_busy: got %b want 0", busy); end
    n_cmp++; if (grant_count !== exp_cnt) begin n_bad++; $display("FAIL relidle_count: got %h want %h", grant_count, exp_cnt); end
    // Release and valid together in IDLE is a normal accept.
    in = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 8'h01;
    n_cmp++; if (out !== 8'h02) begin n_bad++; $display("FAIL relacc_out: got %h want 02", out); end
    n_cmp++; if (grant_count !== exp_cnt) begin n_bad++; $display("FAIL relacc_count: got %h want %h", grant_count, exp_cnt); end
    step();
    grant_release = 1'b0;
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL relacc_rel: got %h want 00", out); end
  endtask

  task automatic test_timeout();
`ifdef GRANT_TIMEOUT_EN
    // HOLD_MAX=4: counter 0 after accept, reaches 4 after 4 edges, revoked at the 5th.
    do_accept(3'd3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out !== 8'h08) begin n_bad++; $display("FAIL to_hold[%0d]: got %h want 08", i, out); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early[%0d]: got %b want 0", i, timeout); end
      step();
    end
    n_cmp++; if (out !== 8'h08) begin n_bad++; $display("FAIL to_last: got %h want 08", out); end
    step();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL to_out: got %h want 00", out); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", timeout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b want 1", in_ready); end
    step();
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_width: got %b want 0", timeout); end
    // Release on the revoke edge wins.
    do_accept(3'd6);
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (out !== 8'h40) begin n_bad++; $display("FAIL to_rel_hold: got %h want 40", out); end
    do_release();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL to_rel_out: got %h want 00", out); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_rel_pulse: got %b want 0", timeout); end
`else
    // Without the timeout feature a grant persists indefinitely.
    do_accept(3'd3);
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (out !== 8'h08) begin n_bad++; $display("FAIL persist[%0d]: got %h want 08", i, out); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL persist_to[%0d]: got %b want 0", i, timeout); end
    end
    do_release();
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL persist_rel: got %h want 00", out); end
`endif
  endtask

  task automatic test_wrap_and_async_reset();
    int n;
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      do_accept(3'(i));
      exp_out = 8'h01 << (i % 8);
      if (i == n - 1) begin
        n_cmp++; if (out !== exp_out) begin n_bad++; $display("FAIL wrap_last_out: got %h want %h", out, exp_out); end
      end
      do_release();
    end
    n_cmp++; if (grant_count !== 8'h00) begin n_bad++; $display("FAIL wrap_count: got %h want 00", grant_count); end
    n_cmp++; if (exp_cnt !== grant_count) begin n_bad++; $display("FAIL wrap_model: got %h want %h", grant_count, exp_cnt); end
    do_accept(3'd4);
    n_cmp++; if (out !== 8'h10) begin n_bad++; $display("FAIL mid_pre: got %h want 10", out); end
    n_cmp++; if (grant_count !== 8'h01) begin n_bad++; $display("FAIL mid_pre_count: got %h want 01", grant_count); end
    // Assert reset between edges; outputs must drop before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL async_out: got %h want 00", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b want 0", busy); end
    n_cmp++; if (grant_count !== 8'h00) begin n_bad++; $display("FAIL async_count: got %h want 00", grant_count); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL async_timeout: got %b want 0", timeout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL async_ready: got %b want 1", in_ready); end
    step();
    rst_n   = 1'b1;
    exp_cnt = 8'h00;
    do_accept(3'd0);
    n_cmp++; if (out !== 8'h01) begin n_bad++; $display("FAIL post_reset_out: got %h want 01", out); end
    n_cmp++; if (grant_count !== 8'h01) begin n_bad++; $display("FAIL post_reset_count: got %h want 01", grant_count); end
    do_release();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_sweep();
    test_ignore_in_grant();
    test_release_idle();
    test_timeout();
    test_wrap_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
